// File: rtl/qam_pkg.sv
// Shared constants for the QAM carrier path (sequencer, CORDIC, mixer).
// Holds the CORDIC angle format, pi/2 in that format, the iteration count
// at which CORDIC results are final, and the sequencer FSM encoding.
package qam_pkg;

  localparam int QAM_ANGLE_W    = 12;    // signed Q2.10 radians
  localparam int QAM_ANGLE_FRAC = 10;
  localparam int QAM_PI_HALF    = 1608;  // pi/2 * 2^10, rounded
  localparam int QAM_ITER_DONE  = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARM     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/phase_fold.sv
// Combinational fold and scale of a full-circle phase into the CORDIC
// convergence range [-pi/2, pi/2).
// Ports:
//   i_phase : unsigned phase, full circle = 2^PHASE_W
//   o_angle : signed Q2.10 CORDIC input angle
//   o_fold  : 1 when the phase was shifted by pi (results must be negated)
module phase_fold
  import qam_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int PI_HALF = QAM_PI_HALF
) (
  input  logic [PHASE_W-1:0]     i_phase,
  output logic [QAM_ANGLE_W-1:0] o_angle,
  output logic                   o_fold
);

  localparam int PROD_W = PHASE_W + QAM_ANGLE_W;
  localparam logic signed [PROD_W-1:0] PI_HALF_S = PROD_W'(PI_HALF);

  logic                      w_fold;
  logic signed [PHASE_W-1:0] w_a;
  logic signed [PROD_W-1:0]  w_prod;

  always_comb begin
    // Quadrants 1 and 2 (top bits 01/10) lie outside +-pi/2; flipping the
    // MSB subtracts pi and lands them back inside.
    w_fold  = i_phase[PHASE_W-1] ^ i_phase[PHASE_W-2];
    w_a     = $signed({i_phase[PHASE_W-1] ^ w_fold, i_phase[PHASE_W-2:0]});
    w_prod  = PROD_W'(w_a) * PI_HALF_S;
    // Quarter circle (2^(PHASE_W-2)) maps to PI_HALF; arithmetic shift
    // floors toward -inf.
    o_angle = QAM_ANGLE_W'(w_prod >>> (PHASE_W - 2));
    o_fold  = w_fold;
  end

endmodule

// File: rtl/cordic_phase_sequencer.sv
// Upstream controller for the iterative CORDIC sin/cos block. Keeps a
// full-circle phase accumulator, folds each phase into the CORDIC range,
// runs the initialize/wait handshake and unfolds the result into a
// registered carrier sample.
// Ports:
//   inp_clk, reset          : clock, synchronous active-high reset
//   enable                  : run back-to-back conversions while high
//   phase_inc               : phase step, added after each capture
//   initialize, inputangle  : CORDIC start pulse and Q2.10 angle
//   cordic_iter             : CORDIC iteration counter
//   cordic_cos, cordic_sin  : CORDIC results (Q2.10)
//   cos_out, sin_out        : unfolded carrier sample
//   out_valid               : one-cycle pulse per new sample
//   busy, err               : not-idle flag, sticky timeout flag
module cordic_phase_sequencer
  import qam_pkg::*;
#(
  parameter int PHASE_W   = 16,
  parameter int PI_HALF   = QAM_PI_HALF,
  parameter int ITER_DONE = QAM_ITER_DONE,
  parameter int TIMEOUT   = 31
) (
  input  logic                   inp_clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PHASE_W-1:0]     phase_inc,
  output logic                   initialize,
  output logic [QAM_ANGLE_W-1:0] inputangle,
  input  logic [3:0]             cordic_iter,
  input  logic [QAM_ANGLE_W-1:0] cordic_cos,
  input  logic [QAM_ANGLE_W-1:0] cordic_sin,
  output logic [QAM_ANGLE_W-1:0] cos_out,
  output logic [QAM_ANGLE_W-1:0] sin_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  seq_state_t                     r_state, w_next;
  logic [PHASE_W-1:0]             r_phase, w_phase_next;
  logic [WAIT_W-1:0]              r_wait;
  logic signed [QAM_ANGLE_W-1:0]  r_angle, r_cos, r_sin;
  logic                           r_fold, r_valid, r_err;
  logic [QAM_ANGLE_W-1:0]         w_angle;
  logic                           w_fold, w_done, w_timeout;

  // Negate when folded; -2048 has no positive twin so it clips to 2047.
  function automatic logic signed [QAM_ANGLE_W-1:0] unfold_sat(
    input logic signed [QAM_ANGLE_W-1:0] x,
    input logic                          neg
  );
    if (!neg)
      return x;
    if (x == {1'b1, {(QAM_ANGLE_W-1){1'b0}}})
      return {1'b0, {(QAM_ANGLE_W-1){1'b1}}};
    return -x;
  endfunction

  // The angle is computed from the phase that will be current in LOAD, so
  // it is already on inputangle while initialize is high.
  phase_fold #(
    .PHASE_W (PHASE_W),
    .PI_HALF (PI_HALF)
  ) u_fold (
    .i_phase (w_phase_next),
    .o_angle (w_angle),
    .o_fold  (w_fold)
  );

  assign w_done    = (cordic_iter == 4'(ITER_DONE));
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    w_next       = r_state;
    w_phase_next = r_phase;
    case (r_state)
      ST_IDLE:    if (enable) w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_ARM;
      // cordic_iter may still show the previous run's done value here.
      ST_ARM:     w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done)         w_next = ST_CAPTURE;
        else if (w_timeout) w_next = ST_LOAD;
      end
      ST_CAPTURE: begin
        w_phase_next = r_phase + phase_inc;
        w_next       = enable ? ST_LOAD : ST_IDLE;
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge inp_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_wait  <= '0;
      r_angle <= '0;
      r_fold  <= 1'b0;
      r_cos   <= '0;
      r_sin   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_next;
      r_valid <= (r_state == ST_CAPTURE);
      if (r_state == ST_ARM)
        r_wait <= '0;
      else if (r_state == ST_WAIT)
        r_wait <= r_wait + 1'b1;
      if (w_next == ST_LOAD) begin
        r_angle <= $signed(w_angle);
        r_fold  <= w_fold;
      end
      if (r_state == ST_WAIT && !w_done && w_timeout)
        r_err <= 1'b1;
      // capture stage: results registered, valid next cycle
      if (r_state == ST_CAPTURE) begin
        r_cos <= unfold_sat($signed(cordic_cos), r_fold);
        r_sin <= unfold_sat($signed(cordic_sin), r_fold);
      end
    end
  end

  assign initialize = (r_state == ST_LOAD);
  assign inputangle = r_angle;
  assign cos_out    = r_cos;
  assign sin_out    = r_sin;
  assign out_valid  = r_valid;
  assign busy       = (r_state != ST_IDLE);
  assign err        = r_err;

endmodule
